id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RV32I core; sits between the decode stage (control_unit, register file, immediate generator) and the execute stage.
- Registers the Ctrl bundle, operands, immediate, PC and register addresses.
- Detects load-use hazards, inserts bubbles, honours branch/jump flush and execute-side hold.
- Counts inserted bubbles for performance monitoring.

Parameters:
N, `Ctrl_length (19), width of the decoded control bundle
XLEN, 32, datapath width
CNT_W, 16, width of the bubble counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a real instruction
id_ctrl  in  N  control bundle from control_unit
id_pc  in  XLEN  PC of the decoded instruction
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
id_imm  in  XLEN  generated immediate
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
ex_hold  in  1  execute/memory not ready; freeze this register
flush  in  1  branch/jump taken in EX; kill the instruction entering EX
ex_valid  out  1  EX-stage instruction valid
ex_ctrl  out  N  registered control bundle
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered datapath values
ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices
stall_id  out  1  hold PC and IF/ID this cycle (combinational)
bubble_cnt  out  CNT_W  number of load-use bubbles inserted

Behaviour:
- Ctrl bit map (MSB to LSB): I_30[18], I_12[17], funct3[16:14], ALUSrc1[13], ALUSrc2[12], Branch[11], ImmType[10:8], RegWrite[7], MemtoReg[6], MemRead[5], MemWrite[4], SignExtendCtrl[3], Jump[2], Lctrl[1], isItype[0].
- Reset (asynchronous, any time, including mid-stall): ex_valid=0, ex_ctrl=0, all data and index outputs=0, bubble_cnt=0. stall_id follows its combinational equation; it is 0 because ex_valid=0.
- Operand usage:
  - uses_rs1 = ~id_ctrl[ALUSrc1] (LUI, AUIPC and JAL read no rs1).
  - uses_rs2 = ~id_ctrl[ALUSrc2] | id_ctrl[MemWrite] (R-type, branch, store).
- Load-use hazard = id_valid & ex_valid & ex_ctrl[MemRead] & (ex_rd != 0) & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- Per-edge priority, highest first:
  1. ex_hold=1: all registers keep their values, including bubble_cnt; flush is ignored. The flush source keeps flush asserted until the hold drops.
  2. flush=1: bubble. ex_valid=0, ex_ctrl=0; data registers may load anything.
  3. hazard=1: bubble as in 2, and bubble_cnt increments.
  4. Otherwise: load. ex_valid=id_valid, ex_ctrl = id_valid ? id_ctrl : 0, all data and index registers load from id_*.
- stall_id = ex_hold | (hazard & ~flush). It is asserted in the same cycle as the hazard. Under flush, upstream kills IF/ID itself.
- Latency: exactly 1 cycle from ID to EX when no stall occurs.
- A load-use hazard stalls exactly 1 cycle. After the bubble, ex_ctrl[MemRead]=0, so the hazard clears and forwarding from MEM covers the dependency.
- x0 destination never causes a stall. A back-to-back load-load dependency stalls 1 cycle, like any other load-use case.
- bubble_cnt wraps modulo 2^CNT_W. Flush bubbles are not counted.
- No combinational path from id_* to ex_* outputs. The only combinational outputs are stall_id and its dependence on id_* and ex_*.

Decomposition:
- define.v gains bit-index macros for every Ctrl field (`CTRL_MEMREAD etc.) and `XLEN; control_unit and this block share them.
- Sub-module: load_use_detect (combinational). Inputs: id_ctrl, id_valid, id_rs1, id_rs2, ex_ctrl, ex_valid, ex_rd. Output: hazard.
- The pipeline register and bubble counter stay in id_ex_stage.

Test Plan:
- Reset asserted asynchronously mid-cycle while ex_valid=1 -> all outputs 0 immediately, bubble_cnt=0, stall_id=0.
- LW x5 followed by ADD x6,x5,x1 -> on the ADD cycle stall_id=1; next edge ex_valid=0, ex_ctrl=0, bubble_cnt=1. Following edge: ADD in EX with ex_rs1=5; stall_id=0.
- LW x0 followed by ADD x6,x0,x0, and LW x5 followed by LUI x5 -> stall_id=0, no bubble, bubble_cnt unchanged.
- LW x5 followed by SW x5,0(x2) (rs2 match) -> 1-cycle stall. LW x5 followed by ADDI x7,x2,4 -> no stall.
- flush=1 with hazard=1 simultaneously -> stall_id=0, ex_valid=0 next edge, bubble_cnt unchanged.
- ex_hold=1 for 3 cycles with id_* changing and flush pulsed -> ex_* stable, stall_id=1 throughout. After release, the next edge loads the current id_* values.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register: datapath widths, the
// control-bundle bit map, and operand-usage helpers used by the hazard logic.
package id_ex_stage_pkg;

  localparam int CTRL_LEN = 19;
  localparam int XLEN     = 32;
  localparam int CNT_W    = 16;

  // Bit positions of the control bundle, MSB to LSB
  localparam int CTRL_I30        = 18;
  localparam int CTRL_I12        = 17;
  localparam int CTRL_FUNCT3_HI  = 16;
  localparam int CTRL_FUNCT3_LO  = 14;
  localparam int CTRL_ALUSRC1    = 13;
  localparam int CTRL_ALUSRC2    = 12;
  localparam int CTRL_BRANCH     = 11;
  localparam int CTRL_IMMTYPE_HI = 10;
  localparam int CTRL_IMMTYPE_LO = 8;
  localparam int CTRL_REGWRITE   = 7;
  localparam int CTRL_MEMTOREG   = 6;
  localparam int CTRL_MEMREAD    = 5;
  localparam int CTRL_MEMWRITE   = 4;
  localparam int CTRL_SIGNEXT    = 3;
  localparam int CTRL_JUMP       = 2;
  localparam int CTRL_LCTRL      = 1;
  localparam int CTRL_ISITYPE    = 0;

  typedef logic [CTRL_LEN-1:0] ctrl_t;
  typedef logic [XLEN-1:0]     word_t;
  typedef logic [4:0]          reg_idx_t;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_HOLD   = 2'd3
  } edge_act_e;

  // ALUSrc1 selects PC/zero instead of rs1 (LUI, AUIPC, JAL)
  function automatic logic uses_rs1(input ctrl_t c);
    return ~c[CTRL_ALUSRC1];
  endfunction

  // Stores take the immediate on ALU port 2 but still read rs2 as write data
  function automatic logic uses_rs2(input ctrl_t c);
    return ~c[CTRL_ALUSRC2] | c[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decode-side inputs, execute-side registered outputs
// and the stall/monitor signals. The stage uses slave, its environment master.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic     id_valid;
  ctrl_t    id_ctrl;
  word_t    id_pc;
  word_t    id_rs1_data;
  word_t    id_rs2_data;
  word_t    id_imm;
  reg_idx_t id_rs1;
  reg_idx_t id_rs2;
  reg_idx_t id_rd;
  logic     ex_hold;
  logic     flush;

  logic     ex_valid;
  ctrl_t    ex_ctrl;
  word_t    ex_pc;
  word_t    ex_rs1_data;
  word_t    ex_rs2_data;
  word_t    ex_imm;
  reg_idx_t ex_rs1;
  reg_idx_t ex_rs2;
  reg_idx_t ex_rd;
  logic     stall_id;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, ex_hold, flush,
    input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, stall_id, bubble_cnt
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, ex_hold, flush,
    output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, stall_id, bubble_cnt
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use detector: flags a decode instruction that reads the
// destination of a load currently in EX (x0 never counts).
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  ctrl_t    id_ctrl,
  input  logic     id_valid,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  ctrl_t    ex_ctrl,
  input  logic     ex_valid,
  input  reg_idx_t ex_rd,
  output logic     hazard
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  assign ex_is_load = ex_valid & ex_ctrl[CTRL_MEMREAD] & (ex_rd != 5'd0);
  assign rs1_match  = uses_rs1(id_ctrl) & (id_rs1 == ex_rd);
  assign rs2_match  = uses_rs2(id_ctrl) & (id_rs2 == ex_rd);
  assign hazard     = id_valid & ex_is_load & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold
// handling, and a counter of inserted load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  logic             hazard;
  edge_act_e        act;

  logic             ex_valid_q;
  ctrl_t            ex_ctrl_q;
  word_t            ex_pc_q;
  word_t            ex_rs1_data_q;
  word_t            ex_rs2_data_q;
  word_t            ex_imm_q;
  reg_idx_t         ex_rs1_q;
  reg_idx_t         ex_rs2_q;
  reg_idx_t         ex_rd_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  load_use_detect u_load_use_detect (
    .id_ctrl  (bus.id_ctrl),
    .id_valid (bus.id_valid),
    .id_rs1   (bus.id_rs1),
    .id_rs2   (bus.id_rs2),
    .ex_ctrl  (ex_ctrl_q),
    .ex_valid (ex_valid_q),
    .ex_rd    (ex_rd_q),
    .hazard   (hazard)
  );

  // Hold beats flush beats hazard; flush bubbles are deliberately not counted
  always_comb begin
    act = ACT_LOAD;
    if (bus.ex_hold) begin
      act = ACT_HOLD;
    end else if (bus.flush) begin
      act = ACT_FLUSH;
    end else if (hazard) begin
      act = ACT_BUBBLE;
    end
  end

  // Under flush the upstream stages kill IF/ID themselves, so no stall then
  assign bus.stall_id = bus.ex_hold | (hazard & ~bus.flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else begin
      case (act)
        ACT_LOAD: begin
          ex_valid_q <= bus.id_valid;
          ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : '0;
        end
        ACT_BUBBLE, ACT_FLUSH: begin
          ex_valid_q <= 1'b0;
          ex_ctrl_q  <= '0;
        end
        default: begin
          ex_valid_q <= ex_valid_q;
          ex_ctrl_q  <= ex_ctrl_q;
        end
      endcase
    end
  end

  // Datapath values are don't-care behind a bubble, so they only move on a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
    end else if (act == ACT_LOAD) begin
      ex_pc_q       <= bus.id_pc;
      ex_rs1_data_q <= bus.id_rs1_data;
      ex_rs2_data_q <= bus.id_rs2_data;
      ex_imm_q      <= bus.id_imm;
      ex_rs1_q      <= bus.id_rs1;
      ex_rs2_q      <= bus.id_rs2;
      ex_rd_q       <= bus.id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (act == ACT_BUBBLE) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_rs1_data = ex_rs1_data_q;
  assign bus.ex_rs2_data = ex_rs2_data_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rs1      = ex_rs1_q;
  assign bus.ex_rs2      = ex_rs2_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a table of instruction-stream vectors plus hand
// sequences for hold and asynchronous reset, checked through a scoreboard.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef enum int {K_LW, K_ADD, K_LUI, K_SW, K_ADDI} kind_e;

  typedef struct {
    logic     valid;
    ctrl_t    ctrl;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     hold;
    logic     flush;
    logic     exp_stall;
    logic     exp_bubble;
    int       exp_cnt;
  } vec_t;

  typedef struct {
    logic     valid;
    ctrl_t    ctrl;
    word_t    pc;
    word_t    rs1_data;
    word_t    rs2_data;
    word_t    imm;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     chk_data;
    int       cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   step;
  exp_t exp_q[$];
  exp_t last_exp;
  vec_t vecs[19];

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ctrl_t ctrl_of(input kind_e k);
    ctrl_t c;
    c = '0;
    case (k)
      K_LW: begin
        c[CTRL_FUNCT3_HI:CTRL_FUNCT3_LO] = 3'b010;
        c[CTRL_ALUSRC2]  = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_MEMTOREG] = 1'b1;
        c[CTRL_MEMREAD]  = 1'b1;
        c[CTRL_SIGNEXT]  = 1'b1;
        c[CTRL_ISITYPE]  = 1'b1;
      end
      K_ADD: c[CTRL_REGWRITE] = 1'b1;
      K_LUI: begin
        c[CTRL_ALUSRC1]  = 1'b1;
        c[CTRL_ALUSRC2]  = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_IMMTYPE_HI:CTRL_IMMTYPE_LO] = 3'b011;
      end
      K_SW: begin
        c[CTRL_FUNCT3_HI:CTRL_FUNCT3_LO] = 3'b010;
        c[CTRL_ALUSRC2]  = 1'b1;
        c[CTRL_MEMWRITE] = 1'b1;
        c[CTRL_IMMTYPE_HI:CTRL_IMMTYPE_LO] = 3'b001;
      end
      default: begin
        c[CTRL_ALUSRC2]  = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ISITYPE]  = 1'b1;
      end
    endcase
    return c;
  endfunction

  function automatic vec_t mk(input logic valid, input kind_e k,
                              input int rs1, input int rs2, input int rd,
                              input logic hold, input logic flush,
                              input logic stall, input logic bubble,
                              input int cnt);
    vec_t v;
    v.valid      = valid;
    v.ctrl       = ctrl_of(k);
    v.rs1        = reg_idx_t'(rs1);
    v.rs2        = reg_idx_t'(rs2);
    v.rd         = reg_idx_t'(rd);
    v.hold       = hold;
    v.flush      = flush;
    v.exp_stall  = stall;
    v.exp_bubble = bubble;
    v.exp_cnt    = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (step %0d): got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic checkExStage();
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard (step %0d): got empty queue expected entry", step);
      return;
    end
    e = exp_q.pop_front();
    checkOutput("ex_valid",   32'(bus.ex_valid),   32'(e.valid));
    checkOutput("ex_ctrl",    32'(bus.ex_ctrl),    32'(e.ctrl));
    checkOutput("bubble_cnt", 32'(bus.bubble_cnt), 32'(e.cnt));
    if (e.chk_data) begin
      checkOutput("ex_pc",       bus.ex_pc,       e.pc);
      checkOutput("ex_rs1_data", bus.ex_rs1_data, e.rs1_data);
      checkOutput("ex_rs2_data", bus.ex_rs2_data, e.rs2_data);
      checkOutput("ex_imm",      bus.ex_imm,      e.imm);
      checkOutput("ex_rs1",      32'(bus.ex_rs1), 32'(e.rs1));
      checkOutput("ex_rs2",      32'(bus.ex_rs2), 32'(e.rs2));
      checkOutput("ex_rd",       32'(bus.ex_rd),  32'(e.rd));
    end
  endtask

  task automatic driveId(input vec_t v);
    bus.id_valid    = v.valid;
    bus.id_ctrl     = v.ctrl;
    bus.id_rs1      = v.rs1;
    bus.id_rs2      = v.rs2;
    bus.id_rd       = v.rd;
    bus.id_pc       = 32'h0000_1000 + 32'(step * 4);
    bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom;
    bus.id_imm      = $urandom;
    bus.ex_hold     = v.hold;
    bus.flush       = v.flush;
  endtask

  // One cycle: drive at negedge, check stall, predict EX, compare after edge
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    driveId(v);
    #1;
    checkOutput("stall_id", 32'(bus.stall_id), 32'(v.exp_stall));
    e = last_exp;
    if (!v.hold) begin
      if (v.exp_bubble) begin
        e.valid    = 1'b0;
        e.ctrl     = '0;
        e.chk_data = 1'b0;
      end else begin
        e.valid    = v.valid;
        e.ctrl     = v.valid ? v.ctrl : '0;
        e.pc       = bus.id_pc;
        e.rs1_data = bus.id_rs1_data;
        e.rs2_data = bus.id_rs2_data;
        e.imm      = bus.id_imm;
        e.rs1      = v.rs1;
        e.rs2      = v.rs2;
        e.rd       = v.rd;
        e.chk_data = 1'b1;
      end
      e.cnt = v.exp_cnt;
    end
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    checkExStage();
    step++;
  endtask

  task automatic clearModel();
    last_exp = '{valid: 1'b0, ctrl: '0, pc: '0, rs1_data: '0, rs2_data: '0,
                 imm: '0, rs1: '0, rs2: '0, rd: '0, chk_data: 1'b1, cnt: 0};
    exp_q.delete();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    step       = 0;
    clearModel();

    //           valid kind   rs1 rs2 rd hold flush stall bubble cnt
    vecs[0]  = mk(1, K_LW,   2,  0,  5, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, K_ADD,  5,  1,  6, 0, 0, 1, 1, 1);
    vecs[2]  = mk(1, K_ADD,  5,  1,  6, 0, 0, 0, 0, 1);
    vecs[3]  = mk(1, K_LW,   2,  0,  0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(1, K_ADD,  0,  0,  6, 0, 0, 0, 0, 1);
    vecs[5]  = mk(1, K_LW,   2,  0,  5, 0, 0, 0, 0, 1);
    vecs[6]  = mk(1, K_LUI,  5,  5,  5, 0, 0, 0, 0, 1);
    vecs[7]  = mk(1, K_LW,   2,  0,  5, 0, 0, 0, 0, 1);
    vecs[8]  = mk(1, K_SW,   2,  5,  0, 0, 0, 1, 1, 2);
    vecs[9]  = mk(1, K_SW,   2,  5,  0, 0, 0, 0, 0, 2);
    vecs[10] = mk(1, K_LW,   2,  0,  5, 0, 0, 0, 0, 2);
    vecs[11] = mk(1, K_ADDI, 2,  5,  7, 0, 0, 0, 0, 2);
    vecs[12] = mk(1, K_LW,   7,  0,  5, 0, 0, 0, 0, 2);
    vecs[13] = mk(1, K_LW,   5,  0,  8, 0, 0, 1, 1, 3);
    vecs[14] = mk(1, K_LW,   5,  0,  8, 0, 0, 0, 0, 3);
    vecs[15] = mk(1, K_ADD,  1,  8,  9, 0, 1, 0, 1, 3);
    vecs[16] = mk(0, K_ADD,  3,  4, 10, 0, 0, 0, 0, 3);
    vecs[17] = mk(1, K_LW,   2,  0,  5, 0, 0, 0, 0, 3);
    vecs[18] = mk(0, K_ADD,  5,  5, 11, 0, 0, 0, 0, 3);

    rst = 1'b1;
    driveId(mk(0, K_ADD, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("reset ex_valid",   32'(bus.ex_valid),   32'd0);
    checkOutput("reset ex_ctrl",    32'(bus.ex_ctrl),    32'd0);
    checkOutput("reset bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
    checkOutput("reset stall_id",   32'(bus.stall_id),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
    end

    // Hold for three cycles over a pending hazard with id changing and flush pulsed
    $display("[TB] hold sequence");
    applyStimulus(mk(1, K_LW,   2, 0, 5, 0, 0, 0, 0, 3));
    applyStimulus(mk(1, K_ADD,  5, 1, 6, 1, 0, 1, 0, 3));
    applyStimulus(mk(1, K_SW,   5, 5, 0, 1, 1, 1, 0, 3));
    applyStimulus(mk(1, K_ADD,  1, 5, 9, 1, 0, 1, 0, 3));
    applyStimulus(mk(1, K_ADDI, 3, 0, 7, 0, 0, 0, 0, 3));

    // Asynchronous reset mid-cycle while a load sits in EX and ID is stalled
    $display("[TB] async reset sequence");
    applyStimulus(mk(1, K_LW, 2, 0, 5, 0, 0, 0, 0, 3));
    @(negedge clk);
    driveId(mk(1, K_ADD, 5, 1, 6, 0, 0, 0, 0, 0));
    #1;
    checkOutput("pre-reset stall_id", 32'(bus.stall_id), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async ex_valid",   32'(bus.ex_valid),   32'd0);
    checkOutput("async ex_ctrl",    32'(bus.ex_ctrl),    32'd0);
    checkOutput("async ex_pc",      bus.ex_pc,           32'd0);
    checkOutput("async ex_rs1_data", bus.ex_rs1_data,    32'd0);
    checkOutput("async ex_rd",      32'(bus.ex_rd),      32'd0);
    checkOutput("async bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
    checkOutput("async stall_id",   32'(bus.stall_id),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    applyStimulus(mk(1, K_ADD, 5, 1, 6, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
